// File: rtl/sampled_toggle_checker.sv
// Sampled-value toggle checker: registers rose/fell/stable/past flags from the
// value of `a` sampled at each posedge, and counts toggling samples and failures
// (MAX_STABLE consecutive non-toggling samples) in saturating counters.
// Optional feature macro: SAMPLED_HIST_EN adds the `hist` sample-history port.
module sampled_toggle_checker #(
  parameter int CNT_W      = 16,
  parameter int MAX_STABLE = 1,
  parameter int HIST_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  output logic             past_a,
  output logic             rose,
  output logic             fell,
  output logic             stable,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       state
`ifdef SAMPLED_HIST_EN
  ,
  output logic [HIST_DEPTH-1:0] hist
`endif
);

  localparam int RUN_W = (MAX_STABLE < 2) ? 1 : $clog2(MAX_STABLE + 1);
  localparam logic [RUN_W:0] RUN_LIMIT = (RUN_W + 1)'(MAX_STABLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic             s_q;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W:0]   run_p1;
  logic             eval;
  logic             toggle;
  logic             run_hit;

  // Saturating increment: all-ones is sticky, counters never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A previous sample is valid once we are past IDLE; evaluate only while enabled.
  assign eval    = en && (cur_state != IDLE);
  assign toggle  = a ^ s_q;
  assign run_p1  = {1'b0, run_len} + (RUN_W + 1)'(1);
  assign run_hit = (run_p1 == RUN_LIMIT);
  assign state   = cur_state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state: en low always returns to IDLE; otherwise IDLE -> PRIME -> CHECK.
  always_comb begin
    nxt_state = cur_state;
    if (!en) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:    nxt_state = PRIME;
        PRIME:   nxt_state = CHECK;
        CHECK:   nxt_state = CHECK;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Sample capture, flags, run length and counters; clr beats counting but not flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= 1'b0;
      past_a   <= 1'b0;
      rose     <= 1'b0;
      fell     <= 1'b0;
      stable   <= 1'b0;
      err      <= 1'b0;
      run_len  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      rose   <= eval & a & ~s_q;
      fell   <= eval & ~a & s_q;
      stable <= eval & ~toggle;
      err    <= 1'b0;
      if (en)   s_q    <= a;
      if (eval) past_a <= s_q;
      if (clr) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        run_len  <= '0;
      end else if (eval) begin
        if (toggle) begin
          pass_cnt <= sat_inc(pass_cnt);
          run_len  <= '0;
        end else if (run_hit) begin
          err      <= 1'b1;
          fail_cnt <= sat_inc(fail_cnt);
          run_len  <= '0;
        end else begin
          run_len  <= run_p1[RUN_W-1:0];
        end
      end else begin
        // Leaving or sitting outside evaluation discards any partial run.
        run_len <= '0;
      end
    end
  end

`ifdef SAMPLED_HIST_EN
  // Sample history, bit0 newest; shifts only while evaluating, holds in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) hist <= '0;
    else if (eval)     hist <= {hist[HIST_DEPTH-2:0], a};
  end
`endif

endmodule

// File: tb/tb_sampled_toggle_checker.sv
// Self-checking bench for sampled_toggle_checker: two instances (MAX_STABLE=1
// and MAX_STABLE=2, 4-bit counters) share stimulus; a behavioural model pushes
// expected outputs to per-instance queues that are popped after each edge.
module tb_sampled_toggle_checker;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, a;
  logic       past1, rose1, fell1, stable1, err1;
  logic       past2, rose2, fell2, stable2, err2;
  logic [3:0] pass1, fail1, pass2, fail2;
  logic [1:0] st1, st2;
`ifdef SAMPLED_HIST_EN
  logic [7:0] hist1, hist2;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] hist;
    logic [1:0] st;
    logic [3:0] pass;
    logic [3:0] fail;
    logic       past;
    logic       rose;
    logic       fell;
    logic       stable;
    logic       err;
  } exp_t;

  exp_t m [2];
  logic ms [2];
  int   mr [2];
  int   maxs [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  sampled_toggle_checker #(.CNT_W(4), .MAX_STABLE(1), .HIST_DEPTH(8)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a),
    .past_a(past1), .rose(rose1), .fell(fell1), .stable(stable1), .err(err1),
    .pass_cnt(pass1), .fail_cnt(fail1), .state(st1)
`ifdef SAMPLED_HIST_EN
    , .hist(hist1)
`endif
  );

  sampled_toggle_checker #(.CNT_W(4), .MAX_STABLE(2), .HIST_DEPTH(8)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a),
    .past_a(past2), .rose(rose2), .fell(fell2), .stable(stable2), .err(err2),
    .pass_cnt(pass2), .fail_cnt(fail2), .state(st2)
`ifdef SAMPLED_HIST_EN
    , .hist(hist2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
    checks++;
    assert (obs === exv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exv);
    end
  endtask

  // Reference behaviour for one instance, evaluated for the upcoming edge.
  task automatic model(input int i);
    logic ev;
    exp_t o;
    o = m[i];
    if (!rst_n) begin
      m[i]  = '0;
      ms[i] = 1'b0;
      mr[i] = 0;
    end else begin
      ev = en && (o.st != 2'd0);
      m[i].rose   = ev && a && !ms[i];
      m[i].fell   = ev && !a && ms[i];
      m[i].stable = ev && (a == ms[i]);
      m[i].err    = 1'b0;
      if (ev) m[i].past = ms[i];
      if (clr) begin
        m[i].pass = 4'd0;
        m[i].fail = 4'd0;
        mr[i] = 0;
        m[i].hist = 8'd0;
      end else if (ev) begin
        m[i].hist = {o.hist[6:0], a};
        if (a != ms[i]) begin
          if (o.pass != 4'hF) m[i].pass = o.pass + 4'd1;
          mr[i] = 0;
        end else if (mr[i] + 1 == maxs[i]) begin
          m[i].err = 1'b1;
          if (o.fail != 4'hF) m[i].fail = o.fail + 4'd1;
          mr[i] = 0;
        end else begin
          mr[i] = mr[i] + 1;
        end
      end else begin
        mr[i] = 0;
      end
      if (en) ms[i] = a;
      if (!en)                 m[i].st = 2'd0;
      else if (o.st == 2'd0)   m[i].st = 2'd1;
      else                     m[i].st = 2'd2;
    end
  endtask

  task automatic compare(input int i);
    exp_t e;
    exp_t o;
    string p;
    p = (i == 0) ? "ms1" : "ms2";
    if (i == 0) begin
      o = '{hist: 8'd0, st: st1, pass: pass1, fail: fail1, past: past1,
            rose: rose1, fell: fell1, stable: stable1, err: err1};
`ifdef SAMPLED_HIST_EN
      o.hist = hist1;
`endif
    end else begin
      o = '{hist: 8'd0, st: st2, pass: pass2, fail: fail2, past: past2,
            rose: rose2, fell: fell2, stable: stable2, err: err2};
`ifdef SAMPLED_HIST_EN
      o.hist = hist2;
`endif
    end
    if (((i == 0) ? q0.size() : q1.size()) == 0) begin
      chk({p, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk({p, "_state"},  32'(o.st),     32'(e.st));
    chk({p, "_pass"},   32'(o.pass),   32'(e.pass));
    chk({p, "_fail"},   32'(o.fail),   32'(e.fail));
    chk({p, "_err"},    32'(o.err),    32'(e.err));
    chk({p, "_rose"},   32'(o.rose),   32'(e.rose));
    chk({p, "_fell"},   32'(o.fell),   32'(e.fell));
    chk({p, "_stable"}, 32'(o.stable), 32'(e.stable));
    chk({p, "_past"},   32'(o.past),   32'(e.past));
`ifdef SAMPLED_HIST_EN
    chk({p, "_hist"},   32'(o.hist),   32'(e.hist));
`endif
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic av);
    @(negedge clk);
    rst_n = r; en = e; clr = c; a = av;
    model(0); q0.push_back(m[0]);
    model(1); q1.push_back(m[1]);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    logic av;
    maxs[0] = 1; maxs[1] = 2;
    m[0] = '0; m[1] = '0; ms[0] = 1'b0; ms[1] = 1'b0; mr[0] = 0; mr[1] = 0;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; a = 1'b0;
    av = 1'b1;

    // Reset with en high and a toggling: everything stays zero.
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 1'b0, av); av = ~av; end

    // Ten toggles: one PRIME edge then nine counted toggles.
    av = 1'b1;
    for (int k = 0; k < 10; k++) begin step(1'b1, 1'b1, 1'b0, av); av = ~av; end
    chk("pass_after_10", 32'(pass1), 32'd9);

    // Drive past saturation of the 4-bit pass counter.
    for (int k = 0; k < 17; k++) begin step(1'b1, 1'b1, 1'b0, av); av = ~av; end
    chk("pass_saturated", 32'(pass2), 32'hF);

    // Hold a for four edges: stable throughout, errors per MAX_STABLE.
    av = ~av;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, av);
    chk("fail_ms2", 32'(fail2), 32'd2);

    // Clear, then five toggles, then clr on a toggling edge.
    step(1'b1, 1'b1, 1'b1, av);
    for (int k = 0; k < 5; k++) begin av = ~av; step(1'b1, 1'b1, 1'b0, av); end
    chk("pass_five", 32'(pass1), 32'd5);
    av = ~av; step(1'b1, 1'b1, 1'b1, av);

    // Start a hold (run_len=1 on MAX_STABLE=2), drop en, then re-enable.
    step(1'b1, 1'b1, 1'b0, av);
    step(1'b1, 1'b0, 1'b0, av);
    step(1'b1, 1'b1, 1'b0, av);
    step(1'b1, 1'b1, 1'b0, av);
    step(1'b1, 1'b1, 1'b0, av);
    step(1'b1, 1'b1, 1'b0, av);

    // clr while disabled, then eight toggles for the history pattern.
    step(1'b1, 1'b0, 1'b1, av);
    av = 1'b0;
    for (int k = 0; k < 9; k++) begin step(1'b1, 1'b1, 1'b0, av); av = ~av; end

    // Final reset mid-run.
    step(1'b0, 1'b1, 1'b0, av);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
